// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_pkg
//  Description : Shared fetch-state encodings and the instruction-alignment
//                mask used by the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    // Fetch sequencer states; DONE doubles as the completion-pulse cycle.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DONE = 2'b10
    } fetch_state_t;

    // Instructions are 32-bit words, so the two address LSBs must be zero.
    localparam logic [1:0] C_ALIGN_MASK = 2'b11;

    // True when the low address bits break word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & C_ALIGN_MASK) != 2'b00;
    endfunction

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_timeout_counter
//  Description : Counts memory wait cycles; flags terminal count when the
//                count reaches TIMEOUT_CYCLES-1. Saturates at terminal.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int C_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_WIDTH-1:0] C_TERM = C_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [C_WIDTH-1:0] r_count;
    logic               w_terminal;

    assign w_terminal = (r_count == C_TERM);
    assign o_terminal = w_terminal;

    // Clear wins over count; hold at terminal so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : fetch_timeout_counter
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Architectural PC register plus a req/ready instruction fetch
//                sequencer with misalignment and timeout reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        pc_en,
    input  logic        fetch_start,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        misaligned,
    output logic        bus_error
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_mem_addr;
    logic         r_mem_req;
    logic         r_busy;
    logic         r_done;
    logic         r_misaligned;
    logic         r_bus_error;

    logic         w_accept;
    logic [31:0]  w_fetch_addr;
    logic         w_terminal;

    // PC and new fetches are only accepted while no request is outstanding.
    assign w_accept = (r_state == FETCH_IDLE) || (r_state == FETCH_DONE);

    // A same-cycle PC load is forwarded so the new target is fetched directly.
    assign w_fetch_addr = (pc_en && fetch_start) ? pc_next : r_pc;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept && fetch_start),
        .i_enable   ((r_state == FETCH_REQ) && !mem_ready),
        .o_terminal (w_terminal)
    );

    // Fetch sequencer, PC register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            // Completion pulse and its flags last a single cycle.
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                FETCH_IDLE, FETCH_DONE: begin
                    if (pc_en) begin
                        r_pc <= pc_next;
                    end
                    if (fetch_start) begin
                        if (is_misaligned(w_fetch_addr[1:0])) begin
                            r_state      <= FETCH_DONE;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state    <= FETCH_REQ;
                            r_mem_req  <= 1'b1;
                            r_busy     <= 1'b1;
                            r_mem_addr <= w_fetch_addr;
                        end
                    end else begin
                        r_state <= FETCH_IDLE;
                    end
                end
                FETCH_REQ: begin
                    // Data arriving on the timeout cycle still counts as success.
                    if (mem_ready) begin
                        r_instr   <= mem_rdata;
                        r_state   <= FETCH_DONE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_terminal) begin
                        r_state     <= FETCH_DONE;
                        r_mem_req   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_bus_error <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= FETCH_IDLE;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign instr      = r_instr;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign fetch_busy = r_busy;
    assign fetch_done = r_done;
    assign misaligned = r_misaligned;
    assign bus_error  = r_bus_error;

endmodule : instruction_fetch
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Owns the architectural program counter and the instruction-fetch handshake of the multi-cycle core.
- Consumes next-PC value and PC write enable produced by the PC-control logic in the register-update stage.
- Fetches the 32-bit instruction word at the current PC over a simple req/ready memory port.
- Presents the latched instruction to decode, with a completion pulse for the stage sequencer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ready before bus error (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pc_next  in  32  next PC from PC-control logic
pc_en  in  1  load pc_next into PC this cycle
fetch_start  in  1  single-cycle request to fetch at current PC
mem_req  out  1  memory read request, registered
mem_addr  out  32  word address to memory, registered, stable while mem_req=1
mem_ready  in  1  memory has valid mem_rdata this cycle
mem_rdata  in  32  instruction word from memory
pc  out  32  current PC register
instr  out  32  last fetched instruction register
fetch_busy  out  1  high in REQ state
fetch_done  out  1  one-cycle pulse: fetch finished (ok or error)
misaligned  out  1  valid with fetch_done: fetch address had addr[1:0]!=0
bus_error  out  1  valid with fetch_done: timeout expired

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, instr=0, mem_req=0, mem_addr=0, fetch_busy=0, fetch_done=0, misaligned=0, bus_error=0, timeout counter=0, state=IDLE.
- States: IDLE, REQ, DONE.
- PC update: pc<=pc_next when pc_en=1 and state is IDLE or DONE. pc_en in REQ is ignored; PC unchanged.
- Effective fetch address:
  - fa = pc_next if pc_en=1 and fetch_start=1 in the same IDLE/DONE cycle (new PC used, no bubble).
  - Otherwise fa = pc.
- IDLE/DONE + fetch_start:
  - fa[1:0]!=0: go to DONE; next cycle fetch_done=1, misaligned=1; mem_req never asserted; instr unchanged.
  - Otherwise: go to REQ; mem_req=1 and mem_addr=fa from the next cycle; counter cleared.
- REQ:
  - mem_req/mem_addr held constant. Counter increments each cycle mem_ready=0.
  - mem_ready=1: instr<=mem_rdata in that cycle; mem_req drops next cycle; go to DONE, fetch_done=1 next cycle with both error flags 0.
  - Counter reaches TIMEOUT_CYCLES-1 with mem_ready=0: go to DONE, fetch_done=1, bus_error=1, instr unchanged.
  - mem_ready=1 on the timeout cycle counts as success.
- DONE: lasts exactly one cycle, then returns to IDLE unless fetch_start is asserted (back-to-back fetch allowed). Error flags clear when fetch_done drops.
- Latency: fetch_start at cycle N, mem_ready at N+1 gives fetch_done at N+2. Minimum fetch-to-fetch spacing is 2 cycles.
- fetch_start in REQ is ignored (no queueing).
- mem_ready outside REQ is ignored.
- Asserting rst_n=0 mid-REQ aborts the fetch immediately: mem_req drops asynchronously and no fetch_done pulse is produced.
- PC arithmetic is not performed here; pc_next is taken verbatim, and wrap-around is the producer's concern.

Decomposition:
- Shared defines file: fetch state encodings (FETCH_IDLE/FETCH_REQ/FETCH_DONE, 2 bits) and the RISC-V instruction-alignment mask constant (2'b11).
- One natural sub-module: fetch_timeout_counter (clear, enable, terminal-count output, parameterised width from TIMEOUT_CYCLES).
- PC register and FSM stay in the top.

Test Plan:
- Reset with RESET_PC=32'h100, then fetch_start → mem_req=1, mem_addr=32'h100 next cycle. mem_ready with rdata 32'h00500093 → instr=32'h00500093 and fetch_done pulse, 2 cycles after start.
- pc_en=1 with pc_next=32'h200 and fetch_start in the same cycle → mem_addr=32'h200, pc=32'h200.
- pc_next=32'h202 loaded, then fetch_start → no mem_req; fetch_done=1 with misaligned=1; instr keeps prior value.
- mem_ready held low with TIMEOUT_CYCLES=4 → fetch_done with bus_error=1 after 4 REQ cycles; mem_req low afterwards.
- pc_en=1 (pc_next=32'hABC0) during REQ and a second fetch_start during REQ → pc unchanged, single fetch_done only.
- rst_n pulsed low mid-REQ → mem_req=0 immediately, pc=RESET_PC, no fetch_done; a subsequent fetch works normally.
